// File: rtl/bf_control_fsm_pkg.sv
// Shared opcodes, widths and controller state encoding for the BF sequencer.
// Optional feature macro: BF_SINGLE_STEP_EN (adds the STALL state).
`default_nettype none

package bf_control_fsm_pkg;

    localparam logic [7:0] OP_INC   = 8'h2B;
    localparam logic [7:0] OP_DEC   = 8'h2D;
    localparam logic [7:0] OP_RIGHT = 8'h3E;
    localparam logic [7:0] OP_LEFT  = 8'h3C;
    localparam logic [7:0] OP_OUT   = 8'h2E;
    localparam logic [7:0] OP_IN    = 8'h2C;
    localparam logic [7:0] OP_JZ    = 8'h5B;
    localparam logic [7:0] OP_JNZ   = 8'h5D;
    localparam logic [7:0] OP_END   = 8'h00;

    localparam int PC_W = 8;

    // Each scan direction is step -> wait (ROM latency) -> check.
    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_FETCH       = 4'd1,
        ST_DECODE      = 4'd2,
        ST_IO_OUT      = 4'd3,
        ST_IO_IN       = 4'd4,
        ST_SCAN_F      = 4'd5,
        ST_SCAN_F_WAIT = 4'd6,
        ST_SCAN_F_CHK  = 4'd7,
        ST_SCAN_B      = 4'd8,
        ST_SCAN_B_WAIT = 4'd9,
        ST_SCAN_B_CHK  = 4'd10,
        ST_HALT        = 4'd11,
        ST_ERROR       = 4'd12
`ifdef BF_SINGLE_STEP_EN
        ,
        ST_STALL       = 4'd13
`endif
    } state_t;

endpackage

`default_nettype wire

// File: rtl/bf_bracket_scan.sv
// Bracket-nesting depth counter used while the controller scans for a match.
`default_nettype none

module bf_bracket_scan
    import bf_control_fsm_pkg::*;
#(
    parameter int DEPTH_W = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       phase,
    input  logic       dir,
    input  logic [7:0] instr,
    output logic       match,
    output logic       overflow
);

    logic [DEPTH_W-1:0] depth;
    logic [7:0]         open_op;
    logic [7:0]         close_op;
    logic               is_open;
    logic               is_close;
    logic               depth_zero;
    logic               depth_full;

    // Scanning backwards swaps which bracket nests and which closes.
    always_comb begin
        open_op    = dir ? OP_JNZ : OP_JZ;
        close_op   = dir ? OP_JZ  : OP_JNZ;
        is_open    = phase && (instr == open_op);
        is_close   = phase && (instr == close_op);
        depth_zero = (depth == '0);
        depth_full = &depth;
        match      = is_close && depth_zero;
        overflow   = is_open && depth_full;
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            depth <= '0;
        end else if (is_open && !depth_full) begin
            depth <= depth + 1'b1;
        end else if (is_close && !depth_zero) begin
            depth <= depth - 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/bf_control_fsm.sv
// BF machine sequencer: fetch/decode, bracket scanning and host I/O handshakes.
// Optional feature macro: BF_SINGLE_STEP_EN (step input, STALL after each retire).
`default_nettype none

module bf_control_fsm
    import bf_control_fsm_pkg::*;
#(
    parameter int DEPTH_W = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] instr,
    input  logic       data_zero,
`ifdef BF_SINGLE_STEP_EN
    input  logic       step,
`endif
    output logic       pc_we,
    output logic       pc_dec_inc,
    output logic       dp_we,
    output logic       dp_dec_inc,
    output logic       d_we,
    output logic       d_dec_inc,
    output logic       d_src_sel,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       in_ready,
    input  logic       in_valid,
    output logic       busy,
    output logic       done,
    output logic       err
);

`ifdef BF_SINGLE_STEP_EN
    localparam state_t RETIRE_ST = ST_STALL;
`else
    localparam state_t RETIRE_ST = ST_FETCH;
`endif

    state_t          state;
    state_t          state_next;
    logic [PC_W-1:0] pc_shadow;
    logic            scan_clear;
    logic            scan_phase;
    logic            scan_dir;
    logic            match;
    logic            overflow;

    bf_bracket_scan #(
        .DEPTH_W (DEPTH_W)
    ) u_scan (
        .clk      (clk),
        .reset    (reset),
        .clear    (scan_clear),
        .phase    (scan_phase),
        .dir      (scan_dir),
        .instr    (instr),
        .match    (match),
        .overflow (overflow)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Mirror of the datapath PC, needed to catch a backward scan wrapping past 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_shadow <= '0;
        end else if (pc_we) begin
            pc_shadow <= pc_dec_inc ? pc_shadow - 1'b1 : pc_shadow + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        pc_we      = 1'b0;
        pc_dec_inc = 1'b0;
        dp_we      = 1'b0;
        dp_dec_inc = 1'b0;
        d_we       = 1'b0;
        d_dec_inc  = 1'b0;
        d_src_sel  = 1'b0;
        out_valid  = 1'b0;
        in_ready   = 1'b0;
        busy       = !(state inside {ST_IDLE, ST_HALT, ST_ERROR});
        done       = (state == ST_HALT);
        err        = (state == ST_ERROR);
        scan_clear = !(state inside {ST_SCAN_F, ST_SCAN_F_WAIT, ST_SCAN_F_CHK,
                                     ST_SCAN_B, ST_SCAN_B_WAIT, ST_SCAN_B_CHK});
        scan_phase = (state inside {ST_SCAN_F_CHK, ST_SCAN_B_CHK});
        scan_dir   = (state inside {ST_SCAN_B, ST_SCAN_B_WAIT, ST_SCAN_B_CHK});

        case (state)
            ST_IDLE, ST_HALT, ST_ERROR: begin
                if (start) state_next = ST_FETCH;
            end
            ST_FETCH: state_next = ST_DECODE;
            ST_DECODE: begin
                case (instr)
                    OP_INC, OP_DEC: begin
                        d_we       = 1'b1;
                        d_dec_inc  = (instr == OP_DEC);
                        pc_we      = 1'b1;
                        state_next = RETIRE_ST;
                    end
                    OP_RIGHT, OP_LEFT: begin
                        dp_we      = 1'b1;
                        dp_dec_inc = (instr == OP_LEFT);
                        pc_we      = 1'b1;
                        state_next = RETIRE_ST;
                    end
                    OP_OUT: state_next = ST_IO_OUT;
                    OP_IN:  state_next = ST_IO_IN;
                    OP_END: state_next = ST_HALT;
                    OP_JZ: begin
                        if (data_zero) begin
                            state_next = ST_SCAN_F;
                        end else begin
                            pc_we      = 1'b1;
                            state_next = RETIRE_ST;
                        end
                    end
                    OP_JNZ: begin
                        if (data_zero) begin
                            pc_we      = 1'b1;
                            state_next = RETIRE_ST;
                        end else begin
                            state_next = ST_SCAN_B;
                        end
                    end
                    default: begin
                        pc_we      = 1'b1;
                        state_next = RETIRE_ST;
                    end
                endcase
            end
            ST_IO_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    pc_we      = 1'b1;
                    state_next = RETIRE_ST;
                end
            end
            ST_IO_IN: begin
                in_ready  = 1'b1;
                d_src_sel = 1'b1;
                if (in_valid) begin
                    d_we       = 1'b1;
                    pc_we      = 1'b1;
                    state_next = RETIRE_ST;
                end
            end
            ST_SCAN_F: begin
                pc_we      = 1'b1;
                state_next = ST_SCAN_F_WAIT;
            end
            ST_SCAN_F_WAIT: state_next = ST_SCAN_F_CHK;
            ST_SCAN_F_CHK: begin
                if (instr == OP_END || overflow) begin
                    state_next = ST_ERROR;
                end else begin
                    // A match steps past the closing bracket and retires the '['.
                    pc_we      = 1'b1;
                    state_next = match ? RETIRE_ST : ST_SCAN_F_WAIT;
                end
            end
            ST_SCAN_B: begin
                if (pc_shadow == '0) begin
                    state_next = ST_ERROR;
                end else begin
                    pc_we      = 1'b1;
                    pc_dec_inc = 1'b1;
                    state_next = ST_SCAN_B_WAIT;
                end
            end
            ST_SCAN_B_WAIT: state_next = ST_SCAN_B_CHK;
            ST_SCAN_B_CHK: begin
                if (instr == OP_END || overflow) begin
                    state_next = ST_ERROR;
                end else if (match) begin
                    pc_we      = 1'b1;
                    state_next = RETIRE_ST;
                end else if (pc_shadow == '0) begin
                    state_next = ST_ERROR;
                end else begin
                    pc_we      = 1'b1;
                    pc_dec_inc = 1'b1;
                    state_next = ST_SCAN_B_WAIT;
                end
            end
`ifdef BF_SINGLE_STEP_EN
            ST_STALL: begin
                if (step) state_next = ST_FETCH;
            end
`endif
            default: state_next = ST_IDLE;
        endcase

        // A reset cycle must never commit a write or keep a handshake open.
        if (reset) begin
            pc_we     = 1'b0;
            dp_we     = 1'b0;
            d_we      = 1'b0;
            d_src_sel = 1'b0;
            out_valid = 1'b0;
            in_ready  = 1'b0;
        end
    end

endmodule

`default_nettype wire
